// File: rtl/sz_quant_packer_pkg.sv
// Shared widths and FSM encoding for the quantization-code packer.
// Imported by the interface and by every packer module.
package sz_quant_packer_pkg;

  localparam int DEF_CODE_W     = 14;
  localparam int DEF_OUT_W      = 64;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CODE_IN_W      = 16;
  localparam int DEF_BITS_W     = $clog2(DEF_OUT_W + 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/sz_quant_packer_if.sv
// Packed-word stream towards the encoder/DMA stage.
// The master drives the head word; the slave drives out_ready.
interface sz_quant_packer_if
  import sz_quant_packer_pkg::*;
#(
  parameter int DATA_W = DEF_OUT_W,
  parameter int BITS_W = DEF_BITS_W
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [BITS_W-1:0] out_bits;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_bits,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_bits,
    output out_ready
  );

endinterface

// File: rtl/sz_quant_packer_sync_fifo.sv
// Show-ahead synchronous FIFO holding {last, bits, data} entries.
// A push into a full FIFO is accepted only when a pop happens that cycle.
module sz_sync_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sz_quant_packer.sv
// Packs 14-bit quant codes LSB-first into 64-bit words with a flush
// terminator; upstream is never stalled, drops set a sticky overflow.
module sz_quant_packer
  import sz_quant_packer_pkg::*;
#(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CODE_IN_W-1:0] code_in,
  input  logic                 code_valid,
  input  logic                 flush,
  sz_quant_packer_if.master    out_if,
  output logic [31:0]          code_count,
  output logic                 overflow,
  output logic                 busy
);

  localparam int ACC_W  = OUT_W + CODE_W;
  localparam int FILL_W = $clog2(OUT_W);
  localparam int BITS_W = $clog2(OUT_W + 1);
  localparam int ENT_W  = 1 + BITS_W + OUT_W;

  localparam logic [FILL_W:0] CODE_V = (FILL_W+1)'(CODE_W);
  localparam logic [FILL_W:0] OUT_V  = (FILL_W+1)'(OUT_W);

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   acc_or;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic [FILL_W:0]    sum;
  logic [FILL_W:0]    over;
  logic               take;
  logic               drop_code;
  logic               push;
  logic               push_last;
  logic [OUT_W-1:0]   push_data;
  logic [BITS_W-1:0]  push_bits;
  logic               full;
  logic               empty;
  logic               pop;
  logic [ENT_W-1:0]   head;
  logic               unused_hi;

  assign unused_hi = ^code_in[CODE_IN_W-1:CODE_W];

  assign sum    = {1'b0, fill_q} + CODE_V;
  assign over   = sum - OUT_V;
  assign acc_or = acc_q | (ACC_W'(code_in[CODE_W-1:0]) << fill_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    take      = 1'b0;
    drop_code = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    push_data = '0;
    push_bits = '0;
    unique case (state_q)
      RUN: begin
        if (code_valid) begin
          take = 1'b1;
          if (sum >= OUT_V) begin
            push      = 1'b1;
            push_data = acc_or[OUT_W-1:0];
            push_bits = BITS_W'(OUT_W);
            acc_d     = acc_or >> OUT_W;
            fill_d    = over[FILL_W-1:0];
          end else begin
            acc_d  = acc_or;
            fill_d = sum[FILL_W-1:0];
          end
        end
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Remainder word: only the low fill bits are live.
        push      = 1'b1;
        push_last = 1'b1;
        push_data = acc_q[OUT_W-1:0] & ~({OUT_W{1'b1}} << fill_q);
        push_bits = BITS_W'(fill_q);
        acc_d     = '0;
        fill_d    = '0;
        drop_code = code_valid;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      acc_q      <= '0;
      fill_q     <= '0;
      code_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      code_count <= code_count + 32'(take);
      overflow   <= overflow | drop_code | (push & full & ~pop);
    end
  end

  sz_sync_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({push_last, push_bits, push_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign pop              = out_if.out_ready & ~empty;
  assign out_if.out_valid = ~empty;
  assign {out_if.out_last, out_if.out_bits, out_if.out_data} = head;

  assign busy = (state_q != RUN) | (fill_q != '0) | ~empty;

endmodule

// File: tb/tb_sz_quant_packer.sv
// Directed bench for sz_quant_packer: reset, packing, flush,
// FIFO overflow and the illegal code-in-FLUSH case.
module tb_sz_quant_packer;
  import sz_quant_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] code_in = '0;
  logic        code_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] code_count;
  logic        overflow;
  logic        busy;

  sz_quant_packer_if ifc ();

  sz_quant_packer dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .flush      (flush),
    .out_if     (ifc),
    .code_count (code_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [63:0]  q_data [$];
  logic [6:0]   q_bits [$];
  logic         q_last [$];
  logic [1023:0] strm;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    if (ifc.out_valid && ifc.out_ready) begin
      q_data.push_back(ifc.out_data);
      q_bits.push_back(ifc.out_bits);
      q_last.push_back(ifc.out_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    q_data.delete();
    q_bits.delete();
    q_last.delete();
  endtask

  task automatic do_reset;
    rst = 1'b0;
    code_valid = 1'b0;
    flush = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
    clear_q();
    strm = '0;
  endtask

  task automatic send(input logic [15:0] c, input int idx);
    code_in = c;
    code_valid = 1'b1;
    strm[idx*14 +: 14] = c[13:0];
    tick;
    code_valid = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 40 && q_data.size() < n; i++) tick;
    repeat (3) tick;
    chk({tag, "_nwords"}, 64'(q_data.size()), 64'(n));
  endtask

  task automatic chk_words(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_w%0d", tag, k), q_data[k], strm[k*64 +: 64]);
      chk($sformatf("%s_b%0d", tag, k), 64'(q_bits[k]), 64'd64);
      chk($sformatf("%s_l%0d", tag, k), 64'(q_last[k]), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.out_ready = 1'b0;
    strm = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_cnt", 64'(code_count), 64'd0);
    chk("rst_data", ifc.out_data, 64'd0);
    do_reset();

    // 1: async reset mid-stream
    for (int i = 0; i < 5; i++) send(16'(i + 1), i);
    chk("t1_pre_valid", 64'(ifc.out_valid), 64'd1);
    chk("t1_pre_cnt", 64'(code_count), 64'd5);
    #3 rst = 1'b0;
    #1;
    chk("t1_valid", 64'(ifc.out_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_ovf", 64'(overflow), 64'd0);
    chk("t1_cnt", 64'(code_count), 64'd0);
    repeat (2) tick;
    rst = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (5) tick;
    chk("t1_nospur", 64'(q_data.size()), 64'd0);

    // 2: 32 incrementing codes -> 7 words
    do_reset();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) send(16'(i), i);
    drain(7, "t2");
    chk("t2_word0", q_data[0], 64'h04000C0020004000);
    chk("t2_word1", q_data[1], 64'h4008001C00600140);
    chk_words(7, "t2");
    chk("t2_cnt", 64'(code_count), 64'd32);
    chk("t2_busy", 64'(busy), 64'd0);

    // 3: all-ones codes then flush
    do_reset();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'hFFFF, i);
    do_flush();
    drain(2, "t3");
    chk("t3_w0", q_data[0], 64'hFFFFFFFFFFFFFFFF);
    chk("t3_b0", 64'(q_bits[0]), 64'd64);
    chk("t3_l0", 64'(q_last[0]), 64'd0);
    chk("t3_w1", q_data[1], 64'h3F);
    chk("t3_b1", 64'(q_bits[1]), 64'd6);
    chk("t3_l1", 64'(q_last[1]), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);

    // 4: overflow on the 5th push with no consumer
    do_reset();
    for (int i = 0; i < 22; i++) send(16'hC000 | 16'(i * 613 + 5), i);
    chk("t4_ovf_pre", 64'(overflow), 64'd0);
    send(16'hC000 | 16'(22 * 613 + 5), 22);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_cnt", 64'(code_count), 64'd23);
    drain(4, "t4");
    chk_words(4, "t4");
    clear_q();
    do_flush();
    drain(1, "t4t");
    chk("t4_term", q_data[0], 64'(strm[320 +: 2]));
    chk("t4_tbits", 64'(q_bits[0]), 64'd2);
    chk("t4_tlast", 64'(q_last[0]), 64'd1);

    // 5: flush with nothing buffered
    do_reset();
    ifc.out_ready = 1'b1;
    do_flush();
    drain(1, "t5");
    chk("t5_w", q_data[0], 64'd0);
    chk("t5_b", 64'(q_bits[0]), 64'd0);
    chk("t5_l", 64'(q_last[0]), 64'd1);

    // 6a: push and pop in the same cycle while full
    do_reset();
    for (int i = 0; i < 22; i++) send(16'(i * 421 + 9), i);
    ifc.out_ready = 1'b1;
    send(16'(22 * 421 + 9), 22);
    drain(5, "t6a");
    chk_words(5, "t6a");
    chk("t6a_ovf", 64'(overflow), 64'd0);

    // 6b: code absorbed with flush, then illegal code in FLUSH
    do_reset();
    ifc.out_ready = 1'b1;
    send(16'h1234, 0);
    send(16'h0ABC, 1);
    code_in = 16'h3FFF;
    code_valid = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    code_in = 16'h1111;
    tick;
    code_valid = 1'b0;
    drain(1, "t6b");
    chk("t6b_ovf", 64'(overflow), 64'd1);
    chk("t6b_cnt", 64'(code_count), 64'd3);
    chk("t6b_w", q_data[0], 64'h000003FFF2AF1234);
    chk("t6b_b", 64'(q_bits[0]), 64'd42);
    chk("t6b_l", 64'(q_last[0]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
